// File: rtl/lift_plant_model.sv
// Cycle-accurate plant model of the lift cabin, door and call panel.
// Consumes controller commands y1..y16 and returns sensors x1..x14 decoded from registered state.
module lift_plant_model #(
    parameter int unsigned FLOORS  = 8,
    parameter int unsigned FLOOR_W = 3,
    parameter int unsigned DOOR_T  = 4,
    parameter int unsigned FLOOR_T = 8,
    parameter int unsigned WDOG_T  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               y1,
    input  logic               y2,
    input  logic               y3,
    input  logic               y4,
    input  logic               y5,
    input  logic               y6,
    input  logic               y7,
    input  logic               y8,
    input  logic               y9,
    input  logic               y10,
    input  logic               y11,
    input  logic               y12,
    input  logic               y13,
    input  logic               y14,
    input  logic               y15,
    input  logic               y16,
    input  logic               call_req,
    input  logic [FLOOR_W-1:0] call_floor,
    output logic               x1,
    output logic               x2,
    output logic               x3,
    output logic               x4,
    output logic               x5,
    output logic               x6,
    output logic               x7,
    output logic               x8,
    output logic               x9,
    output logic               x10,
    output logic               x11,
    output logic               x12,
    output logic               x13,
    output logic               x14
);

    localparam int unsigned TRAVEL_W = (FLOOR_T > 1) ? $clog2(FLOOR_T) : 1;
    localparam int unsigned WDOG_W   = $clog2(WDOG_T + 1);

    localparam logic [DOOR_T-1:0]   DoorLast   = DOOR_T'(DOOR_T - 1);
    localparam logic [TRAVEL_W-1:0] TravelLast = TRAVEL_W'(FLOOR_T - 1);
    localparam logic [FLOOR_W-1:0]  PosTop     = FLOOR_W'(FLOORS - 1);
    localparam logic [WDOG_W-1:0]   WdogMax    = WDOG_W'(WDOG_T);

    typedef enum logic [1:0] {DoorOpen, DoorClosing, DoorClosed, DoorOpening} door_e;
    typedef enum logic [1:0] {MotorStop, MotorUp, MotorDown} motor_e;

    door_e               door_q, door_d;
    motor_e              motor_q, motor_d;
    logic [DOOR_T-1:0]   door_cnt_q, door_cnt_d;
    logic [TRAVEL_W-1:0] travel_cnt_q, travel_cnt_d;
    logic [FLOOR_W-1:0]  pos_q, pos_d;
    logic [FLOOR_W-1:0]  target_q, target_d;
    logic                pending_q, pending_d;
    logic                pass_q, pass_d;
    logic                clear_q, clear_d;
    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic                fault_q, fault_d;

    logic                move_ok;
    logic                move_up;
    logic                move_dn;
    logic [FLOOR_W-1:0]  pos_step;

    logic unused_cmds;
    assign unused_cmds = ^{y1, y5, y7, y8, y9, y10, y11, y12, y13};

    always_ff @(posedge clk) begin
        if (rst) begin
            door_q       <= DoorOpen;
            motor_q      <= MotorStop;
            door_cnt_q   <= '0;
            travel_cnt_q <= '0;
            pos_q        <= '0;
            target_q     <= '0;
            pending_q    <= 1'b0;
            pass_q       <= 1'b0;
            clear_q      <= 1'b0;
            wdog_cnt_q   <= '0;
            fault_q      <= 1'b0;
        end else begin
            door_q       <= door_d;
            motor_q      <= motor_d;
            door_cnt_q   <= door_cnt_d;
            travel_cnt_q <= travel_cnt_d;
            pos_q        <= pos_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            pass_q       <= pass_d;
            clear_q      <= clear_d;
            wdog_cnt_q   <= wdog_cnt_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        door_d       = door_q;
        door_cnt_d   = door_cnt_q;
        motor_d      = motor_q;
        travel_cnt_d = travel_cnt_q;
        pos_d        = pos_q;
        pass_d       = 1'b0;
        target_d     = target_q;
        pending_d    = pending_q;
        clear_d      = 1'b0;
        wdog_cnt_d   = wdog_cnt_q;
        fault_d      = fault_q;
        pos_step     = pos_q;

        // y2 beats any move request; y3 with y4 cancels both
        move_ok = ~y2 & (y3 ^ y4) & (door_q == DoorClosed) & (motor_q == MotorStop);
        move_up = move_ok & y3 & (pos_q != PosTop);
        move_dn = move_ok & y4 & (pos_q != '0);

        if (y2) begin
            motor_d      = MotorStop;
            travel_cnt_d = '0;
        end else if (move_up) begin
            motor_d      = MotorUp;
            travel_cnt_d = '0;
        end else if (move_dn) begin
            motor_d      = MotorDown;
            travel_cnt_d = '0;
        end else if (motor_q != MotorStop) begin
            if (travel_cnt_q == TravelLast) begin
                travel_cnt_d = '0;
                pass_d       = 1'b1;
                pos_step     = (motor_q == MotorUp) ? pos_q + FLOOR_W'(1) : pos_q - FLOOR_W'(1);
                pos_d        = pos_step;
                if (pos_step == '0 || pos_step == PosTop) begin
                    motor_d = MotorStop;
                end
            end else begin
                travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
            end
        end

        case (door_q)
            DoorOpen: begin
                if (y14 & y15) begin
                    door_d     = DoorClosing;
                    door_cnt_d = '0;
                end
            end
            DoorClosing: begin
                if (door_cnt_q == DoorLast) begin
                    door_d     = DoorClosed;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_T'(1);
                end
            end
            DoorClosed: begin
                // a move accepted on the same edge keeps the door shut
                if (y16 & (motor_q == MotorStop) & ~move_up & ~move_dn) begin
                    door_d     = DoorOpening;
                    door_cnt_d = '0;
                end
            end
            DoorOpening: begin
                if (door_cnt_q == DoorLast) begin
                    door_d     = DoorOpen;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_T'(1);
                end
            end
            default: begin
                door_d     = DoorOpen;
                door_cnt_d = '0;
            end
        endcase

        if (y6 & pending_q) begin
            pending_d = 1'b0;
            clear_d   = 1'b1;
        end else if (call_req & ~pending_q & (32'(call_floor) < FLOORS)) begin
            pending_d = 1'b1;
            target_d  = call_floor;
        end

        if (pending_q && door_q == DoorClosed && motor_q == MotorStop) begin
            if (wdog_cnt_q != WdogMax) begin
                wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end
            if (wdog_cnt_d == WdogMax) begin
                fault_d = 1'b1;
            end
        end else begin
            wdog_cnt_d = '0;
        end
    end

    always_comb begin
        x1  = pending_q;
        x2  = (door_q == DoorClosed);
        x3  = (pos_q == '0);
        x4  = pending_q & (target_q > pos_q);
        x5  = pending_q & (target_q < pos_q);
        x6  = pending_q & (target_q == pos_q);
        x7  = 1'b0;
        x8  = 1'b0;
        x9  = 1'b0;
        x10 = pass_q;
        x11 = clear_q;
        x12 = (door_q == DoorOpen);
        x13 = (motor_q == MotorStop);
        x14 = fault_q;
    end

endmodule

// File: tb/tb_lift_plant_model.sv
// Directed bench for lift_plant_model: a vector table for the main closed-loop walk,
// plus hand sequences for reset mid-travel, top-floor auto-stop, watchdog and call/clear race.
module tb_lift_plant_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:1] yv  = '0;
    logic        call_req   = 1'b0;
    logic [2:0]  call_floor = '0;
    logic [14:1] xv;
    logic x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign xv = {x14, x13, x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1};

    lift_plant_model #(
        .FLOORS (8),
        .FLOOR_W(3),
        .DOOR_T (4),
        .FLOOR_T(8),
        .WDOG_T (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y1        (yv[1]),
        .y2        (yv[2]),
        .y3        (yv[3]),
        .y4        (yv[4]),
        .y5        (yv[5]),
        .y6        (yv[6]),
        .y7        (yv[7]),
        .y8        (yv[8]),
        .y9        (yv[9]),
        .y10       (yv[10]),
        .y11       (yv[11]),
        .y12       (yv[12]),
        .y13       (yv[13]),
        .y14       (yv[14]),
        .y15       (yv[15]),
        .y16       (yv[16]),
        .call_req  (call_req),
        .call_floor(call_floor),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .x5        (x5),
        .x6        (x6),
        .x7        (x7),
        .x8        (x8),
        .x9        (x9),
        .x10       (x10),
        .x11       (x11),
        .x12       (x12),
        .x13       (x13),
        .x14       (x14)
    );

    typedef struct {
        logic [16:1] y;
        logic        creq;
        logic [2:0]  cf;
        int          reps;
        logic [14:1] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:1] yb(input int n);
        logic [16:1] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [14:1] xb(input int n);
        logic [14:1] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Inputs are presented for exactly one rising edge; outputs sampled 1 time unit later.
    task automatic step(input logic [16:1] y, input logic creq, input logic [2:0] cf);
        yv         = y;
        call_req   = creq;
        call_floor = cf;
        @(posedge clk);
        #1;
        yv         = '0;
        call_req   = 1'b0;
        call_floor = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 3'd0);
    endtask

    task automatic check(input string name, input logic [14:1] exp);
        n_cmp++;
        if (xv !== exp) begin
            n_err++;
            $display("FAIL %s: x14..x1 got %b required %b", name, xv, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input logic [16:1] y, input logic creq, input logic [2:0] cf,
                       input int reps, input logic [14:1] exp);
        vec_t v;
        v.y    = y;
        v.creq = creq;
        v.cf   = cf;
        v.reps = reps;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [16:1] y2, y3, y4, y6, y14, y15, y16, ign;
        logic [14:1] rs;
        y2  = yb(2);
        y3  = yb(3);
        y4  = yb(4);
        y6  = yb(6);
        y14 = yb(14);
        y15 = yb(15);
        y16 = yb(16);
        ign = yb(1) | yb(5) | yb(7) | yb(8) | yb(9) | yb(10) | yb(11) | yb(12) | yb(13) | y15;
        rs  = xb(3) | xb(12) | xb(13);

        // Main walk: call to floor 2, close, travel up two floors, stop, clear, reopen.
        add('0,        1'b0, 3'd0, 1, rs);
        add(ign,       1'b0, 3'd0, 1, rs);
        add(y3,        1'b0, 3'd0, 1, rs);
        add(y14,       1'b0, 3'd0, 1, rs);
        add(y3 | y4,   1'b0, 3'd0, 1, rs);
        add('0,        1'b1, 3'd2, 1, xb(1) | xb(4) | rs);
        add('0,        1'b1, 3'd5, 1, xb(1) | xb(4) | rs);
        add(y14 | y15, 1'b0, 3'd0, 4, xb(1) | xb(4) | xb(3) | xb(13));
        add('0,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(4) | xb(3) | xb(13));
        add(y3 | y4,   1'b0, 3'd0, 1, xb(1) | xb(2) | xb(4) | xb(3) | xb(13));
        add(y3,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(4) | xb(3));
        add(y16,       1'b0, 3'd0, 1, xb(1) | xb(2) | xb(4) | xb(3));
        add(y14,       1'b0, 3'd0, 6, xb(1) | xb(2) | xb(4) | xb(3));
        add('0,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(4) | xb(10));
        add(y16,       1'b0, 3'd0, 7, xb(1) | xb(2) | xb(4));
        add('0,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(6) | xb(10));
        add('0,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(6));
        add(y2,        1'b0, 3'd0, 1, xb(1) | xb(2) | xb(6) | xb(13));
        add(y6,        1'b0, 3'd0, 1, xb(2) | xb(11) | xb(13));
        add('0,        1'b0, 3'd0, 1, xb(2) | xb(13));
        add(y6,        1'b0, 3'd0, 1, xb(2) | xb(13));
        add(y16,       1'b0, 3'd0, 4, xb(13));
        add('0,        1'b0, 3'd0, 1, xb(12) | xb(13));

        do_reset();
        check("reset", rs);
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                if (r == 0) step(vecs[i].y, vecs[i].creq, vecs[i].cf);
                else        step('0, 1'b0, 3'd0);
                check($sformatf("vec%0d.%0d", i, r), vecs[i].exp);
            end
        end

        // Reset held two cycles while travelling up past floor 3.
        do_reset();
        step('0, 1'b1, 3'd3);
        step(y14 | y15, 1'b0, 3'd0);
        idle(4);
        step(y3, 1'b0, 3'd0);
        idle(24);
        check("rst_pre_pos3", xb(1) | xb(2) | xb(6) | xb(10));
        idle(3);
        check("rst_moving", xb(1) | xb(2) | xb(6));
        do_reset();
        check("rst_mid_travel", rs);
        idle(1);
        check("rst_after", rs);

        // Auto-stop at the top floor, then a further y3 is ignored.
        do_reset();
        step('0, 1'b1, 3'd7);
        check("top_call", xb(1) | xb(4) | rs);
        step(y14 | y15, 1'b0, 3'd0);
        idle(4);
        check("top_closed", xb(1) | xb(2) | xb(4) | xb(3) | xb(13));
        step(y3, 1'b0, 3'd0);
        idle(55);
        check("top_pos6", xb(1) | xb(2) | xb(4));
        idle(1);
        check("top_autostop", xb(1) | xb(2) | xb(6) | xb(10) | xb(13));
        step(y3, 1'b0, 3'd0);
        check("top_y3_ignored", xb(1) | xb(2) | xb(6) | xb(13));
        idle(1);
        check("top_still_stop", xb(1) | xb(2) | xb(6) | xb(13));

        // Watchdog: 64 qualifying edges start on the edge after the door reports closed.
        do_reset();
        step('0, 1'b1, 3'd3);
        step(y14 | y15, 1'b0, 3'd0);
        idle(4);
        check("wd_closed", xb(1) | xb(2) | xb(4) | xb(3) | xb(13));
        idle(63);
        check("wd_63", xb(1) | xb(2) | xb(4) | xb(3) | xb(13));
        idle(1);
        check("wd_64", xb(1) | xb(2) | xb(4) | xb(3) | xb(13) | xb(14));
        step(y6, 1'b0, 3'd0);
        check("wd_sticky_y6", xb(2) | xb(3) | xb(11) | xb(13) | xb(14));
        step(y16, 1'b0, 3'd0);
        idle(4);
        check("wd_sticky_open", rs | xb(14));
        do_reset();
        check("wd_rst_clears", rs);

        // Clear and new call on the same edge: clear wins, new call dropped.
        step('0, 1'b1, 3'd4);
        check("race_call", xb(1) | xb(4) | rs);
        step(y6, 1'b1, 3'd1);
        check("race_clear", xb(11) | rs);
        idle(1);
        check("race_pulse_once", rs);
        step('0, 1'b1, 3'd0);
        check("race_new_call", xb(1) | xb(6) | rs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
